// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle for one TMDS channel encoder.
// master: drives iVD/iCD/iVDE and observes oTMDS/oDisparity.
// slave: the encoder side of the same bundle.
interface tmds_channel_encoder_if;
    logic [7:0]        iVD;
    logic [1:0]        iCD;
    logic              iVDE;
    logic [9:0]        oTMDS;
    logic signed [4:0] oDisparity;

    modport master (
        output iVD, iCD, iVDE,
        input  oTMDS, oDisparity
    );

    modport slave (
        input  iVD, iCD, iVDE,
        output oTMDS, oDisparity
    );
endinterface

// File: rtl/tmds_channel_encoder.sv
// DVI 8b/10b TMDS channel encoder with running disparity.
// Ports: clock_pixel, reset (sync, active-high), bus (slave):
//   iVD data byte, iCD {C1,C0}, iVDE active video,
//   oTMDS symbol (bit 0 first), oDisparity signed running disparity.
// Latency 2 clocks; define TMDS_OUTREG_EN for an extra output
// register (latency 3).
module tmds_channel_encoder #(
    parameter logic [1:0] CTRL_RESET = 2'b00
) (
    input logic                   clock_pixel,
    input logic                   reset,
    tmds_channel_encoder_if.slave bus
);

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    localparam logic [9:0] RESET_SYM = ctrl_sym(CTRL_RESET);

    // Stage 1: transition-minimising q_m
    logic [3:0] n1_d;
    logic       use_xnor;
    logic [8:0] qm_d;

    assign n1_d     = 4'($countones(bus.iVD));
    assign use_xnor = (n1_d > 4'd4) ||
                      ((n1_d == 4'd4) && !bus.iVD[0]);

    always_comb begin
        logic [8:0] q;
        q    = '0;
        q[0] = bus.iVD[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ bus.iVD[i])
                            :  (q[i-1] ^ bus.iVD[i]);
        end
        q[8] = ~use_xnor;
        qm_d = q;
    end

    logic       vde_r;
    logic [1:0] cd_r;
    logic [8:0] qm_r;

    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            vde_r <= 1'b0;
            cd_r  <= CTRL_RESET;
            qm_r  <= '0;
        end else begin
            vde_r <= bus.iVDE;
            cd_r  <= bus.iCD;
            qm_r  <= qm_d;
        end
    end

    // Stage 2: DC balancing against running disparity
    logic signed [4:0] n1;
    logic signed [4:0] n0;
    logic signed [4:0] diff;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_d;
    logic [9:0]        sym_d;
    logic [9:0]        sym_r;
    logic              q8;

    assign n1   = 5'($countones(qm_r[7:0]));
    assign n0   = 5'sd8 - n1;
    assign diff = n1 - n0;
    assign q8   = qm_r[8];

    always_comb begin
        sym_d = ctrl_sym(cd_r);
        cnt_d = '0;
        if (vde_r) begin
            unique case (1'b1)
                (cnt == 5'sd0) || (diff == 5'sd0): begin
                    sym_d = {~q8, q8, q8 ? qm_r[7:0] : ~qm_r[7:0]};
                    cnt_d = q8 ? cnt + diff : cnt - diff;
                end
                ((cnt > 5'sd0) && (diff > 5'sd0)) ||
                ((cnt < 5'sd0) && (diff < 5'sd0)): begin
                    sym_d = {1'b1, q8, ~qm_r[7:0]};
                    cnt_d = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
                end
                default: begin
                    sym_d = {1'b0, q8, qm_r[7:0]};
                    cnt_d = cnt - (q8 ? 5'sd0 : 5'sd2) + diff;
                end
            endcase
        end
    end

    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            sym_r <= RESET_SYM;
            cnt   <= '0;
        end else begin
            sym_r <= sym_d;
            cnt   <= cnt_d;
        end
    end

`ifdef TMDS_OUTREG_EN
    logic [9:0]        out_sym;
    logic signed [4:0] out_disp;

    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            out_sym  <= 10'h354;
            out_disp <= '0;
        end else begin
            out_sym  <= sym_r;
            out_disp <= cnt;
        end
    end

    assign bus.oTMDS      = out_sym;
    assign bus.oDisparity = out_disp;
`else
    assign bus.oTMDS      = sym_r;
    assign bus.oDisparity = cnt;
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: directed plan
// steps with literal expectations, then randomized traffic.
module tb_tmds_channel_encoder;

`ifdef TMDS_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    tmds_channel_encoder_if bus ();

    tmds_channel_encoder #(.CTRL_RESET(2'b00)) dut (
        .clock_pixel (clk),
        .reset       (reset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [9:0] sym;
        int       disp;
        bit       lit;
        bit [9:0] lsym;
        int       ldisp;
    } exp_t;

    exp_t q[$];
    int   cnt_m = 0;
    int   vectors = 0;
    int   errs = 0;
    bit [9:0] ctrl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    // Reference: encode one input word, updating the model disparity.
    function automatic void enc(input bit vde, input bit [1:0] cd,
                                input bit [7:0] d, inout int c,
                                output bit [9:0] sym);
        int  ones, m, z;
        bit  xn, b8;
        bit [7:0] qm;
        if (!vde) begin
            sym = ctrl_tab[cd];
            c   = 0;
            return;
        end
        ones = $countones(d);
        xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        b8 = !xn;
        m  = $countones(qm);
        z  = 8 - m;
        if (c == 0 || m == z) begin
            sym = {!b8, b8, b8 ? qm : ~qm};
            c   = c + (b8 ? m - z : z - m);
        end else if ((c > 0 && m > z) || (c < 0 && z > m)) begin
            sym = {1'b1, b8, ~qm};
            c   = c + 2 * int'(b8) + (z - m);
        end else begin
            sym = {1'b0, b8, qm};
            c   = c - 2 * int'(!b8) + (m - z);
        end
    endfunction

    task automatic step(input bit r, input bit vde,
                        input bit [1:0] cd, input bit [7:0] vd,
                        input bit lit = 1'b0,
                        input bit [9:0] lsym = 10'h0,
                        input int ldisp = 0);
        exp_t     e;
        bit [9:0] s;
        int       od;
        @(negedge clk);
        reset    = r;
        bus.iVDE = vde;
        bus.iCD  = cd;
        bus.iVD  = vd;
        if (r) begin
            q.delete();
            cnt_m = 0;
            for (int i = 0; i < LAT; i++)
                q.push_back('{ctrl_tab[0], 0, 1'b1, 10'h354, 0});
        end else begin
            enc(vde, cd, vd, cnt_m, s);
            q.push_back('{s, cnt_m, lit, lsym, ldisp});
        end
        @(posedge clk);
        #1;
        od = int'($signed(bus.oDisparity));
        vectors++;
        assert (q.size() > 0) else begin
            errs++;
            $error("FAIL queue empty got %0d want >0", q.size());
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            assert (bus.oTMDS === e.sym) else begin
                errs++;
                $error("FAIL sym got %h want %h", bus.oTMDS, e.sym);
            end
            vectors++;
            assert (od === e.disp) else begin
                errs++;
                $error("FAIL disp got %0d want %0d", od, e.disp);
            end
            if (e.lit) begin
                vectors++;
                assert (bus.oTMDS === e.lsym) else begin
                    errs++;
                    $error("FAIL plan_sym got %h want %h",
                           bus.oTMDS, e.lsym);
                end
                vectors++;
                assert (od === e.ldisp) else begin
                    errs++;
                    $error("FAIL plan_disp got %0d want %0d",
                           od, e.ldisp);
                end
            end
        end
    endtask

    task automatic flush();
        for (int i = 0; i < LAT; i++) step(0, 0, 2'b00, 8'h00);
    endtask

    initial begin
        bus.iVD  = '0;
        bus.iCD  = '0;
        bus.iVDE = 1'b0;

        // 1: reset, then the reset symbol holds
        step(1, 0, 2'b00, 8'h00);
        step(0, 0, 2'b00, 8'h00, 1, 10'h354, 0);
        step(0, 0, 2'b00, 8'h00, 1, 10'h354, 0);

        // 2: control codes
        step(0, 0, 2'b00, 8'h5A, 1, 10'h354, 0);
        step(0, 0, 2'b01, 8'h5A, 1, 10'h0AB, 0);
        step(0, 0, 2'b10, 8'h5A, 1, 10'h154, 0);
        step(0, 0, 2'b11, 8'h5A, 1, 10'h2AB, 0);

        // 3: zeros from cnt=0
        step(0, 0, 2'b00, 8'h00);
        step(0, 1, 2'b11, 8'h00, 1, 10'h100, -8);
        step(0, 1, 2'b10, 8'h00, 1, 10'h3FF, 2);
        step(0, 1, 2'b01, 8'h00, 1, 10'h100, -6);

        // 4: 0xFF from cnt=0
        step(0, 0, 2'b00, 8'h00);
        step(0, 1, 2'b00, 8'hFF, 1, 10'h200, -8);

        // 5: blanking clears disparity
        step(0, 0, 2'b00, 8'h00);
        step(0, 1, 2'b00, 8'h00, 1, 10'h100, -8);
        step(0, 0, 2'b00, 8'h00, 1, 10'h354, 0);
        step(0, 1, 2'b00, 8'h00, 1, 10'h100, -8);

        // 6: mid-stream reset with cnt=+2
        step(0, 0, 2'b00, 8'h00);
        step(0, 1, 2'b00, 8'h00, 1, 10'h100, -8);
        step(0, 1, 2'b00, 8'h00, 1, 10'h3FF, 2);
        step(1, 1, 2'b11, 8'hA7);
        step(0, 1, 2'b00, 8'h00, 1, 10'h100, -8);
        flush();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)));
        end
        flush();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
